// File: rtl/cpu_flags_stack_pkg.sv
// ============================================================================
// Module  : cpu_flags_stack_pkg
// Brief   : Shared sizes, field positions and FSM encoding for the flag unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_flags_stack_pkg;

  localparam int DEF_N_FLAGS     = 4;
  localparam int DEF_N_THREADS   = 4;
  localparam int DEF_STACK_DEPTH = 4;

  // Bit positions inside stack_err
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_UDF_BIT = 1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Address width that never collapses to zero bits
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpu_flags_stack_if.sv
// ============================================================================
// Module  : cpu_flags_stack_if
// Brief   : Decoder-side command/status bundle of the per-thread flag unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_flags_stack_if
  import cpu_flags_stack_pkg::*;
#(
  parameter int N         = DEF_N_FLAGS,
  parameter int N_THREADS = DEF_N_THREADS
);
  localparam int TW    = clog2_min1(N_THREADS);
  localparam int IDX_W = clog2_min1(N);

  logic             ready;
  logic [TW-1:0]    thread_num;
  logic             load_en;
  logic             save_en;
  logic             push_en;
  logic             pop_en;
  logic             set_flags;
  logic [N-1:0]     iop_flag_mask;
  logic [N-1:0]     flags_in;
  logic [IDX_W+1:0] op_condition;
  logic             condition_is_true;
  logic [N-1:0]     flags;
  logic [1:0]       stack_err;
  logic [TW-1:0]    err_thread;

  modport master (
    input  ready, condition_is_true, flags, stack_err, err_thread,
    output thread_num, load_en, save_en, push_en, pop_en, set_flags,
           iop_flag_mask, flags_in, op_condition
  );

  modport slave (
    output ready, condition_is_true, flags, stack_err, err_thread,
    input  thread_num, load_en, save_en, push_en, pop_en, set_flags,
           iop_flag_mask, flags_in, op_condition
  );

endinterface

`default_nettype wire

// File: rtl/cpu_flags_stack_ram.sv
// ============================================================================
// Module  : flags_thread_ram
// Brief   : Distributed RAM, one synchronous write port, one async read port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module flags_thread_ram #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  wire logic             clk,
  input  wire logic             i_we,
  input  wire logic [AW-1:0]    i_waddr,
  input  wire logic [WIDTH-1:0] i_wdata,
  input  wire logic [AW-1:0]    i_raddr,
  output logic      [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Async read returns the pre-write contents during a same-cycle write
  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/cpu_flags_stack.sv
// ============================================================================
// Module  : cpu_flags_stack
// Brief   : Per-thread flag register, save/restore words and flag stack.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_flags_stack
  import cpu_flags_stack_pkg::*;
#(
  parameter int N           = DEF_N_FLAGS,
  parameter int N_THREADS   = DEF_N_THREADS,
  parameter int STACK_DEPTH = DEF_STACK_DEPTH
) (
  input  wire logic        CLK,
  input  wire logic        RESET_N,
  cpu_flags_stack_if.slave bus
);

  localparam int TW    = clog2_min1(N_THREADS);
  localparam int IDX_W = clog2_min1(N);
  localparam int SLW   = clog2_min1(STACK_DEPTH);
  localparam int SPW   = SLW + 1;
  localparam int SAW   = TW + SLW;

  localparam logic [TW-1:0]  c_LAST_THREAD = TW'(N_THREADS - 1);
  localparam logic [SPW-1:0] c_SP_FULL     = SPW'(STACK_DEPTH);

  state_t           r_state;
  state_t           w_state_next;
  logic [TW-1:0]    r_init_cnt;
  logic [N-1:0]     r_flags;
  logic [N-1:0]     w_flags_next;
  logic [SPW-1:0]   r_sp [N_THREADS];
  logic [1:0]       r_err;
  logic [1:0]       w_err_next;
  logic [TW-1:0]    r_err_thread;

  logic             w_run;
  logic [TW-1:0]    w_thr;
  logic [SPW-1:0]   w_sp;
  logic [SPW-1:0]   w_sp_m1;
  logic [SPW-1:0]   w_sp_next;
  logic             w_sp_we;
  logic             w_load;
  logic             w_save;
  logic             w_push_req;
  logic             w_pop_req;
  logic             w_set;
  logic             w_pop_ok;
  logic             w_pop_udf;
  logic             w_push_replace;
  logic             w_push_ok;
  logic             w_push_ovf;

  logic             w_save_we;
  logic [TW-1:0]    w_save_waddr;
  logic [N-1:0]     w_save_wdata;
  logic [N-1:0]     w_save_rd;
  logic             w_stk_we;
  logic [SAW-1:0]   w_stk_waddr;
  logic [SAW-1:0]   w_stk_raddr;
  logic [N-1:0]     w_stk_rd;

  logic [IDX_W-1:0] w_cond_idx;
  logic             w_cond_inv;
  logic             w_cond_en;
  logic             w_cond_in_range;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= ST_INIT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_INIT: if (r_init_cnt == c_LAST_THREAD) w_state_next = ST_RUN;
      ST_RUN:  w_state_next = ST_RUN;
      default: w_state_next = ST_INIT;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_init_cnt <= '0;
    end else if (r_state == ST_INIT) begin
      r_init_cnt <= r_init_cnt + TW'(1);
    end
  end

  assign w_run = (r_state == ST_RUN);

  // ---------------------------------------------------------------- command decode
  assign w_thr   = bus.thread_num;
  assign w_sp    = r_sp[w_thr];
  assign w_sp_m1 = w_sp - SPW'(1);

  assign w_load     = w_run & bus.load_en;
  assign w_save     = w_run & bus.save_en;
  assign w_push_req = w_run & bus.push_en;
  assign w_pop_req  = w_run & bus.pop_en & ~bus.load_en;
  assign w_set      = w_run & bus.set_flags & ~bus.load_en & ~bus.pop_en;

  assign w_pop_ok  = w_pop_req & (w_sp != '0);
  assign w_pop_udf = w_pop_req & (w_sp == '0);

  // A push alongside a successful pop rewrites the old top in place
  assign w_push_replace = w_push_req & w_pop_ok;
  assign w_push_ok      = w_push_req & ~w_pop_ok & (w_sp != c_SP_FULL);
  assign w_push_ovf     = w_push_req & ~w_pop_ok & (w_sp == c_SP_FULL);

  always_comb begin
    w_sp_we   = 1'b0;
    w_sp_next = w_sp;
    if (w_push_ok) begin
      w_sp_we   = 1'b1;
      w_sp_next = w_sp + SPW'(1);
    end else if (w_pop_ok && !w_push_replace) begin
      w_sp_we   = 1'b1;
      w_sp_next = w_sp_m1;
    end
  end

  generate
    for (genvar t = 0; t < N_THREADS; t++) begin : g_sp
      always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
          r_sp[t] <= '0;
        end else if (w_sp_we && (w_thr == TW'(t))) begin
          r_sp[t] <= w_sp_next;
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------- storage
  assign w_save_we    = ~w_run | w_save;
  assign w_save_waddr = w_run ? w_thr : r_init_cnt;
  assign w_save_wdata = w_run ? r_flags : '0;

  flags_thread_ram #(
    .WIDTH (N),
    .DEPTH (N_THREADS),
    .AW    (TW)
  ) u_save_ram (
    .clk     (CLK),
    .i_we    (w_save_we),
    .i_waddr (w_save_waddr),
    .i_wdata (w_save_wdata),
    .i_raddr (w_thr),
    .o_rdata (w_save_rd)
  );

  assign w_stk_we    = w_push_ok | w_push_replace;
  assign w_stk_waddr = {w_thr, (w_push_replace ? w_sp_m1[SLW-1:0] : w_sp[SLW-1:0])};
  assign w_stk_raddr = {w_thr, w_sp_m1[SLW-1:0]};

  flags_thread_ram #(
    .WIDTH (N),
    .DEPTH (N_THREADS * STACK_DEPTH),
    .AW    (SAW)
  ) u_stack_ram (
    .clk     (CLK),
    .i_we    (w_stk_we),
    .i_waddr (w_stk_waddr),
    .i_wdata (r_flags),
    .i_raddr (w_stk_raddr),
    .o_rdata (w_stk_rd)
  );

  // ---------------------------------------------------------------- flags and errors
  always_comb begin
    w_flags_next = r_flags;
    if (w_load) begin
      w_flags_next = w_save_rd;
    end else if (w_pop_ok) begin
      w_flags_next = w_stk_rd;
    end else if (w_set) begin
      w_flags_next = (r_flags & ~bus.iop_flag_mask) | (bus.flags_in & bus.iop_flag_mask);
    end
  end

  always_comb begin
    w_err_next              = r_err;
    w_err_next[ERR_OVF_BIT] = r_err[ERR_OVF_BIT] | w_push_ovf;
    w_err_next[ERR_UDF_BIT] = r_err[ERR_UDF_BIT] | w_pop_udf;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_flags      <= '0;
      r_err        <= '0;
      r_err_thread <= '0;
    end else begin
      r_flags <= w_flags_next;
      r_err   <= w_err_next;
      if ((r_err == 2'b00) && (w_err_next != 2'b00)) begin
        r_err_thread <= w_thr;
      end
    end
  end

  // ---------------------------------------------------------------- condition
  assign w_cond_idx      = bus.op_condition[IDX_W-1:0];
  assign w_cond_inv      = bus.op_condition[IDX_W];
  assign w_cond_en       = bus.op_condition[IDX_W+1];
  assign w_cond_in_range = (32'(w_cond_idx) < N);

  assign bus.condition_is_true = ~w_cond_en |
                                 (w_cond_in_range & (r_flags[w_cond_idx] ^ w_cond_inv));

  assign bus.ready      = w_run;
  assign bus.flags      = r_flags;
  assign bus.stack_err  = r_err;
  assign bus.err_thread = r_err_thread;

endmodule

`default_nettype wire

// File: tb/tb_cpu_flags_stack.sv
// ============================================================================
// Module  : tb_cpu_flags_stack
// Brief   : Scoreboard bench for the per-thread flag unit (4 flags, 4 threads).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_flags_stack;

  localparam int K_FLAGS = 0;
  localparam int K_ERR   = 1;
  localparam int K_ETHR  = 2;
  localparam int K_READY = 3;
  localparam int K_COND  = 4;

  typedef struct {
    int          kind;
    string       tag;
    logic [31:0] exp;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET_N = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  cpu_flags_stack_if bus ();

  cpu_flags_stack u_dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      K_FLAGS: return 32'(bus.flags);
      K_ERR:   return 32'(bus.stack_err);
      K_ETHR:  return 32'(bus.err_thread);
      K_READY: return 32'(bus.ready);
      K_COND:  return 32'(bus.condition_is_true);
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic expect_out(input int kind, input string tag, input logic [31:0] exp);
    exp_t e;
    e.kind = kind;
    e.tag  = tag;
    e.exp  = exp;
    sb.push_back(e);
  endtask

  task automatic idle();
    bus.thread_num    = '0;
    bus.load_en       = 1'b0;
    bus.save_en       = 1'b0;
    bus.push_en       = 1'b0;
    bus.pop_en        = 1'b0;
    bus.set_flags     = 1'b0;
    bus.iop_flag_mask = '0;
    bus.flags_in      = '0;
  endtask

  task automatic set_cmd(input int thr, input bit ld, input bit sv, input bit pu, input bit po,
                         input bit sf, input logic [3:0] mask, input logic [3:0] din);
    bus.thread_num    = 2'(thr);
    bus.load_en       = ld;
    bus.save_en       = sv;
    bus.push_en       = pu;
    bus.pop_en        = po;
    bus.set_flags     = sf;
    bus.iop_flag_mask = mask;
    bus.flags_in      = din;
  endtask

  // Apply the pending command on the next edge, then retire every queued expectation
  task automatic step();
    exp_t e;
    @(posedge CLK);
    #1;
    idle();
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.kind), e.exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int cycles;
    cycles = 0;
    while (!bus.ready && cycles < 20) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    check(tag, 32'(cycles), 32'd4);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    bus.op_condition = '0;
    #12;
    check("rst_flags", 32'(bus.flags), 32'h0);
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_err", 32'(bus.stack_err), 32'h0);
    check("rst_ethr", 32'(bus.err_thread), 32'h0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    wait_ready("ready_latency");

    set_cmd(2, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "load_t2_init", 32'h0);
    step();

    // Masked update and condition decoding
    set_cmd(0, 0, 0, 0, 0, 1, 4'b0101, 4'b1111);
    expect_out(K_FLAGS, "set_masked", 32'h5);
    step();
    bus.op_condition = {1'b1, 1'b0, 2'd1};
    expect_out(K_COND, "cond_en_idx1", 32'h0);
    step();
    bus.op_condition = {1'b1, 1'b1, 2'd1};
    expect_out(K_COND, "cond_inv_idx1", 32'h1);
    step();
    bus.op_condition = {1'b1, 1'b0, 2'd2};
    expect_out(K_COND, "cond_en_idx2", 32'h1);
    step();
    bus.op_condition = {1'b1, 1'b1, 2'd0};
    expect_out(K_COND, "cond_inv_idx0", 32'h0);
    step();
    bus.op_condition = {1'b0, 1'b1, 2'd3};
    expect_out(K_COND, "cond_disabled", 32'h1);
    step();

    // Save / load per thread
    set_cmd(1, 0, 0, 0, 0, 1, 4'hF, 4'hA);
    expect_out(K_FLAGS, "set_A", 32'hA);
    step();
    set_cmd(1, 0, 1, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "save_t1_hold", 32'hA);
    step();
    set_cmd(3, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "load_t3", 32'h0);
    step();
    set_cmd(1, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "load_t1", 32'hA);
    step();
    set_cmd(3, 1, 0, 0, 0, 1, 4'hF, 4'hF);
    expect_out(K_FLAGS, "load_beats_set", 32'h0);
    step();

    // Stack fill, overflow, drain, underflow on thread 1
    for (int v = 1; v <= 4; v++) begin
      set_cmd(1, 0, 0, 0, 0, 1, 4'hF, 4'(v));
      step();
      set_cmd(1, 0, 0, 1, 0, 0, 4'h0, 4'h0);
      expect_out(K_ERR, "push_no_err", 32'h0);
      step();
    end
    set_cmd(1, 0, 0, 0, 0, 1, 4'hF, 4'h5);
    step();
    set_cmd(1, 0, 0, 1, 0, 0, 4'h0, 4'h0);
    expect_out(K_ERR, "overflow", 32'h1);
    expect_out(K_ETHR, "overflow_thr", 32'h1);
    expect_out(K_FLAGS, "overflow_flags", 32'h5);
    step();
    for (int v = 4; v >= 1; v--) begin
      set_cmd(1, 0, 0, 0, 1, 0, 4'h0, 4'h0);
      expect_out(K_FLAGS, $sformatf("pop_%0d", v), 32'(v));
      step();
    end
    set_cmd(1, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    expect_out(K_ERR, "underflow", 32'h3);
    expect_out(K_FLAGS, "underflow_flags", 32'h1);
    expect_out(K_ETHR, "underflow_thr", 32'h1);
    step();

    // Simultaneous push and pop on thread 2
    set_cmd(2, 0, 0, 0, 0, 1, 4'hF, 4'h7);
    step();
    set_cmd(2, 0, 0, 1, 0, 0, 4'h0, 4'h0);
    step();
    set_cmd(2, 0, 0, 0, 0, 1, 4'hF, 4'h9);
    step();
    set_cmd(2, 0, 0, 1, 1, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "pushpop_flags", 32'h7);
    step();
    set_cmd(2, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "pushpop_new_top", 32'h9);
    step();
    set_cmd(2, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "pushpop_sp_empty", 32'h9);
    step();

    // Same-cycle save and load reads the old word
    set_cmd(0, 1, 1, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "rbw_load_old", 32'h0);
    step();
    set_cmd(0, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "rbw_saved_new", 32'h9);
    step();

    // Reset in the middle of a push
    set_cmd(0, 0, 0, 0, 0, 1, 4'hF, 4'h3);
    step();
    set_cmd(0, 0, 0, 1, 0, 0, 4'h0, 4'h0);
    @(posedge CLK);
    #3;
    RESET_N = 1'b0;
    #1;
    check("midrst_flags", 32'(bus.flags), 32'h0);
    check("midrst_err", 32'(bus.stack_err), 32'h0);
    check("midrst_ready", 32'(bus.ready), 32'h0);
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;
    set_cmd(0, 0, 0, 0, 0, 1, 4'hF, 4'hF);
    wait_ready("ready_latency_2");
    idle();
    check("init_ignores_cmds", 32'(bus.flags), 32'h0);
    set_cmd(0, 0, 0, 0, 1, 0, 4'h0, 4'h0);
    expect_out(K_ERR, "post_rst_underflow", 32'h2);
    expect_out(K_ETHR, "post_rst_ethr", 32'h0);
    step();
    set_cmd(1, 1, 0, 0, 0, 0, 4'h0, 4'h0);
    expect_out(K_FLAGS, "post_rst_t1_cleared", 32'h0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
